// File: rtl/rs232_result_streamer.sv
// Avalon-MM master for the RS232 UART core: optional RX start command,
// start strobe to the core, and byte-serial transmission of buffered results.
module rs232_result_streamer #(
    parameter int         DATA_W        = 32,
    parameter int         FIFO_DEPTH    = 4,
    parameter int         MSB_FIRST     = 1,
    parameter int         WAIT_RX_START = 0,
    parameter logic [7:0] START_BYTE    = 8'h53
) (
    input  logic              avm_clk,
    input  logic              avm_rst,
    output logic [4:0]        avm_address,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic              i_res_valid,
    input  logic [DATA_W-1:0] i_res_data,
    output logic              o_res_ready,
    output logic              o_start,
    output logic              o_busy,
    output logic [15:0]       o_words_sent,
    output logic              o_overflow
);

    localparam int NBYTES = DATA_W / 8;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [4:0] ADDR_RX     = 5'd0;
    localparam logic [4:0] ADDR_TX     = 5'd4;
    localparam logic [4:0] ADDR_STATUS = 5'd8;

    localparam int TX_RDY = 6;
    localparam int RX_RDY = 7;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RX_POLL,
        S_RX_READ,
        S_START,
        S_WAIT,
        S_WRX_POLL,
        S_WRX_READ,
        S_TX_POLL,
        S_TX_WRITE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [15:0]       words_q, words_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic       done;
    logic       push;
    logic       pop;
    logic       full;
    logic       last_byte;
    logic       rx_match;
    logic [7:0] cur_byte;
    logic       unused_rd;

    assign unused_rd = ^avm_readdata[31:8];

    assign done      = ~avm_waitrequest;
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign pop       = (state_q == S_WAIT) && (count_q != '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
    assign o_res_ready = ~full | pop;
    assign push      = i_res_valid & o_res_ready;
    assign last_byte = (byte_cnt_q == BCW'(NBYTES - 1));
    assign rx_match  = (avm_readdata[7:0] == START_BYTE);

    assign cur_byte = (MSB_FIRST != 0) ? shreg_q[DATA_W-1 -: 8]
                                       : shreg_q[7:0];

    assign o_busy       = (count_q != '0) ||
                          (state_q == S_TX_POLL) ||
                          (state_q == S_TX_WRITE);
    assign o_words_sent = words_q;
    assign o_overflow   = ovf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        byte_cnt_d    = byte_cnt_q;
        words_d       = words_q;
        ovf_d         = ovf_q | (i_res_valid & ~o_res_ready);
        avm_address   = ADDR_STATUS;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = 32'd0;
        o_start       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = (WAIT_RX_START != 0) ? S_RX_POLL : S_START;
            end
            S_RX_POLL: begin
                avm_read = 1'b1;
                if (done) begin
                    state_d = avm_readdata[RX_RDY] ? S_RX_READ : S_RX_POLL;
                end
            end
            S_RX_READ: begin
                avm_address = ADDR_RX;
                avm_read    = 1'b1;
                if (done) begin
                    state_d = rx_match ? S_START : S_RX_POLL;
                end
            end
            S_START: begin
                o_start = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (count_q != '0) begin
                    shreg_d    = mem_q[rd_ptr_q];
                    byte_cnt_d = '0;
                    state_d    = S_TX_POLL;
                end else if (WAIT_RX_START != 0) begin
                    state_d = S_WRX_POLL;
                end
            end
            S_WRX_POLL: begin
                avm_read = 1'b1;
                if (done) begin
                    // Pending results win over a waiting RX byte.
                    if (avm_readdata[RX_RDY] && (count_q == '0)) begin
                        state_d = S_WRX_READ;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WRX_READ: begin
                avm_address = ADDR_RX;
                avm_read    = 1'b1;
                if (done) begin
                    state_d = rx_match ? S_START : S_WAIT;
                end
            end
            S_TX_POLL: begin
                avm_read = 1'b1;
                if (done && avm_readdata[TX_RDY]) begin
                    state_d = S_TX_WRITE;
                end
            end
            S_TX_WRITE: begin
                avm_address   = ADDR_TX;
                avm_write     = 1'b1;
                avm_writedata = {24'd0, cur_byte};
                if (done) begin
                    shreg_d = (MSB_FIRST != 0) ? (shreg_q << 8)
                                               : (shreg_q >> 8);
                    if (last_byte) begin
                        words_d = words_q + 16'd1;
                        state_d = S_WAIT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = S_TX_POLL;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            words_q    <= 16'd0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            words_q    <= words_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge avm_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_res_data;
        end
    end

endmodule

// File: doc/rs232_result_streamer.md
Name: rs232_result_streamer

Overview:
- Avalon-MM master that drives the Altera RS232 UART core: optionally waits for a start command byte on RX, pulses a start strobe to the compute core, buffers result words, and serialises each word byte-by-byte to TX using status polling.
- Generalised successor of the single-word ecall sender: parametrised word width, result FIFO depth, byte order and RX-triggered start.
- Sits between the CPU top (o_start / result push) and the UART Avalon slave.

Parameters:
- DATA_W, 32, result word width in bits; must be a multiple of 8, range 8..256; NBYTES = DATA_W/8.
- FIFO_DEPTH, 4, result words buffered; power of 2, at least 2.
- MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant byte first.
- WAIT_RX_START, 0, 1 = o_start is issued only after START_BYTE is received on RX; 0 = o_start is issued one cycle after reset release.
- START_BYTE, 8'h53, RX command byte that triggers o_start.

Ports:
- avm_clk  in  1  clock
- avm_rst  in  1  reset, asynchronous, active-high
- avm_address  out  5  UART register byte address: RX=0, TX=4, STATUS=8
- avm_read  out  1  Avalon read request
- avm_readdata  in  32  read data; STATUS bit6 = TX ready, bit7 = RX ready; RX byte in [7:0]
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  {24'b0, tx_byte}
- avm_waitrequest  in  1  slave stall
- i_res_valid  in  1  result word offered
- i_res_data  in  DATA_W  result word
- o_res_ready  out  1  FIFO not full
- o_start  out  1  one-cycle start strobe to core
- o_busy  out  1  high when FIFO non-empty or a word is being transmitted
- o_words_sent  out  16  count of fully transmitted words; wraps at 65535 -> 0
- o_overflow  out  1  sticky: i_res_valid asserted while o_res_ready=0

Behaviour:
- Reset values: avm_address=8, avm_read=0, avm_write=0, avm_writedata=0, o_start=0, o_res_ready=1, o_busy=0, o_words_sent=0, o_overflow=0; FIFO empty; state IDLE.
- Avalon rule: once read or write is asserted, address, read, write and writedata are held stable until a cycle with avm_waitrequest=0. The transfer completes in that cycle, and readdata is sampled in the same cycle. No back-to-back reuse of stale readdata.
- FIFO push: i_res_valid && o_res_ready. Push and pop in the same cycle are both honoured, including when the FIFO is full. The dropped word on overflow is discarded and o_overflow is set.
- States:
  - IDLE: go to RX_POLL if WAIT_RX_START=1, else START.
  - RX_POLL: read STATUS. On completion with bit7=1, go to RX_READ; else re-issue the read on the next cycle.
  - RX_READ: read RX. On completion, if readdata[7:0]==START_BYTE go to START, else go to RX_POLL.
  - START: o_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: if the FIFO is non-empty, pop into the shift register, set byte_cnt=0, go to TX_POLL. In WAIT_RX_START=1 mode, RX is also polled here; START_BYTE re-issues o_start, and other bytes are ignored.
  - TX_POLL: read STATUS. On completion with bit6=1, go to TX_WRITE; else re-poll.
  - TX_WRITE: write the current byte to TX. The current byte is shreg[DATA_W-1 -: 8] if MSB_FIRST=1, else shreg[7:0]. On completion, shift the register by 8 toward the sent end. If byte_cnt==NBYTES-1, increment o_words_sent and go to WAIT; else increment byte_cnt and go to TX_POLL.
- Latency: with waitrequest=0 and TX always ready, one byte takes 2 cycles (poll + write). Pop to first write completion is 3 cycles.
- o_busy = (FIFO count != 0) || state in {TX_POLL, TX_WRITE}.
- RX polling in WAIT runs only while the FIFO is empty. TX has priority.
- Reset mid-transfer aborts immediately to reset values; a partially sent word is lost.

Test Plan:
- WAIT_RX_START=0, DATA_W=32, MSB_FIRST=1, push 32'hDEADBEEF, waitrequest=0, TX always ready -> TX writes DE, AD, BE, EF in order; o_words_sent=1; o_start pulses once, 1 cycle after reset release.
- MSB_FIRST=0, DATA_W=64, push 64'h0102030405060708 -> TX writes 08, 07, …, 01; exactly 8 TX writes.
- STATUS bit6 held 0 for 5 polls, with waitrequest=1 for 3 cycles per transfer -> address, read and write stay stable while stalled; no TX write until bit6=1; byte sequence unchanged.
- WAIT_RX_START=1: RX delivers 8'h41 then 8'h53 -> no o_start after 8'h41; exactly one o_start pulse after 8'h53.
- FIFO_DEPTH=4, push 6 words back-to-back while TX is stalled -> o_res_ready=0 after 4 words (5 if one has already been popped); o_overflow=1; all accepted words are transmitted in order.
- Assert avm_rst during byte 2 of a word -> all outputs return to reset values immediately; after release, a new push is sent starting from byte 0.
